// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encodings and default width for the serial subtractor
package sub_pkg;

  localparam int SUB_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_sub_bit.sv
// rtl/full_sub_bit.sv - one-bit full subtractor cell: d = a - b - bin
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_two_values_serial.sv
// rtl/sub_two_values_serial.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module sub_two_values_serial
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic w_d;
  logic w_br;

  full_sub_bit u_bit (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_br)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= ain;
            r_b     <= bin;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SUB;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SUB: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          // Last bit: publish using the cell outputs directly since r_res is not yet updated
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_diff  <= {w_d, r_res[WIDTH-1:1]};
            r_bout  <= w_br;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_sub_two_values_serial.sv
// tb/tb_sub_two_values_serial.sv - randomized self-checking bench for sub_two_values_serial
module tb_sub_two_values_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] ain = '0;
  logic [3:0] bin = '0;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       bout;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] prev_diff = '0;
  logic       prev_bout = 1'b0;

  sub_two_values_serial #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ain   (ain),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_diff(input logic [3:0] a, input logic [3:0] b);
    return 4'((int'(a) - int'(b) + 16) % 16);
  endfunction

  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    ain   = a;
    bin   = b;
    start = 1'b1;
  endtask

  // Drops start after the capture edge, scrambles inputs (and optionally pokes start) while busy
  task automatic finish_op(input logic [3:0] a, input logic [3:0] b, input bit spur, input string tag);
    int n;
    int busy_cnt;
    bit moved;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    moved = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (diff !== prev_diff || bout !== prev_bout) moved = 1;
      ain   = 4'($urandom);
      bin   = 4'($urandom);
      start = (spur && n >= 1 && n <= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, n, 4);
    check({tag, "_busy_cycles"}, busy_cnt, 4);
    check({tag, "_hold"}, moved, 0);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_diff"}, diff, ref_diff(a, b));
    check({tag, "_bout"}, bout, (a < b));
    @(negedge clk);
    check({tag, "_single_done"}, done, 0);
    check({tag, "_idle_after"}, busy, 0);
    prev_diff = ref_diff(a, b);
    prev_bout = (a < b);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit spur, input string tag);
    launch(a, b);
    finish_op(a, b, spur, tag);
  endtask

  initial begin
    int n;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd9,  4'd5,  0, "sub_9_5");
    run_op(4'd3,  4'd7,  0, "sub_3_7");
    run_op(4'd0,  4'd15, 0, "sub_0_15");
    run_op(4'd15, 4'd15, 0, "sub_15_15");
    run_op(4'd9,  4'd5,  1, "start_while_busy");

    // Back-to-back: start held through the done cycle
    launch(4'd9, 4'd5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    check("b2b_first_latency", n, 5);
    check("b2b_first_diff", diff, 4);
    ain = 4'd2;
    bin = 4'd6;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!done && n < 20);
    check("b2b_second_latency", n, 5);
    check("b2b_second_diff", diff, 12);
    check("b2b_second_bout", bout, 1);
    @(negedge clk);
    check("b2b_single_done", done, 0);
    prev_diff = 4'd12;
    prev_bout = 1'b1;

    // Reset two cycles into an operation
    launch(4'd9, 4'd5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_diff", diff, 0);
    check("midrst_bout", bout, 0);
    prev_diff = '0;
    prev_bout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ain   = 4'd6;
    bin   = 4'd1;
    start = 1'b1;
    finish_op(4'd6, 4'd1, 0, "after_reset_6_1");

    for (int i = 0; i < 40; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      a = 4'($urandom);
      b = 4'($urandom);
      run_op(a, b, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
